mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//   Shares one single-port, variable-latency memory bus between instruction fetch (I) and the MEM-stage data access (D).
//   Sits between the pipeline's fetch/mem stages and the memory; arbitrates, sequences one transaction at a time,
//   returns read data and a one-cycle ready pulse the pipeline uses to release its stall.
// PARAMETERS
//   ADDR_W    32   address width, both ports and bus
//   DATA_W    32   data width; byte strobes are DATA_W/8 wide
//   MAX_WAIT  255  bus cycles without m_ack before watchdog abort; must be >= 1
// PORTS
//   clk       in   1         clock, rising edge
//   rst       in   1         synchronous reset, active-low (rst==0 resets on the clock edge)
//   i_req     in   1         fetch request; held high until i_ready
//   i_addr    in   ADDR_W    fetch address (read only)
//   i_rdata   out  DATA_W    fetch read data; valid while i_ready==1
//   i_ready   out  1         one-cycle completion pulse to fetch
//   d_req     in   1         data request; held high, with fields stable, until d_ready
//   d_we      in   1         1 = write, 0 = read
//   d_wstrb   in   DATA_W/8  byte-write strobes (ignored on reads)
//   d_addr    in   ADDR_W    data address
//   d_wdata   in   DATA_W    write data
//   d_rdata   out  DATA_W    data read data; valid while d_ready==1
//   d_ready   out  1         one-cycle completion pulse to MEM stage
//   m_req     out  1         bus request; held until m_ack or abort
//   m_we, m_wstrb, m_addr, m_wdata  out  -  bus command fields, registered at grant, stable while m_req==1
//   m_rdata   in   DATA_W    bus read data, sampled when m_ack==1
//   m_ack     in   1         bus completion, one cycle
//   bus_err   out  1         one-cycle pulse, coincident with the ready pulse, on watchdog abort
// BEHAVIOUR
//   - All outputs registered. Reset: state IDLE, every output 0, watchdog 0, owner = D.
//   - FSM: IDLE -> BUS on any request; BUS -> RESP on m_ack or watchdog expiry; RESP -> IDLE unconditionally.
//   - IDLE: grant per priority rule; latch owner and command fields; assert m_req next cycle.
//     I grant forces m_we=0 and m_wstrb=0.
//   - BUS: m_req=1; watchdog increments each cycle.
//     On m_ack: capture m_rdata into owner's rdata, drop m_req, go RESP.
//   - RESP: owner's ready=1 for exactly this cycle; no arbitration.
//     Requester's req in this cycle is stale and ignored; it is re-evaluated in IDLE.
//   - Latency: req seen in IDLE at cycle 0 -> m_req=1 cycle 1 -> m_ack earliest cycle 1 -> ready at cycle 2.
//     Minimum 3 cycles between successive grants.
//   - Watchdog: if the count reaches MAX_WAIT with no m_ack, drop m_req and go RESP.
//     Owner's ready=1, rdata=0, bus_err=1. Watchdog clears on entry to BUS.
//   - m_ack and expiry in the same cycle: the ack wins, and bus_err stays 0.
//   - m_ack seen in IDLE or RESP (stray, or late after abort): ignored, no output change.
//   - Non-owner rdata/ready stay 0. The non-owner request waits; no request is dropped.
//   - Reset mid-transaction: m_req deasserts on that edge. The pending ack is discarded; no ready pulse is issued.
// CONFIGURATION
//   ARB_RR_EN undefined: fixed priority, D over I (older instruction first; prevents MEM/IF deadlock).
//   ARB_RR_EN defined: round-robin. When both request in IDLE, grant the port not served last.
//     Last-served pointer updates on each grant; reset value = I, so D wins the first tie.
//   Single requester: granted immediately in both modes.
// STRUCTURE
//   - Shared header define_arb.vh: FSM state encodings (ARB_IDLE, ARB_BUS, ARB_RESP) and owner codes (ARB_OWN_I, ARB_OWN_D).
//   - One sub-module, arb_grant_sel: combinational grant from i_req, d_req and the last-served pointer.
//     Built in fixed or RR form under ARB_RR_EN.
//   - FSM, watchdog and command/response registers live in mem_bus_arbiter.
// TESTING
//   - Reset: rst=0 for 2 cycles with i_req=d_req=1 -> all outputs 0. First grant appears the cycle after rst=1.
//   - D write, 0-wait: d_req, d_we=1, addr=0x10, wdata=0xDEADBEEF, wstrb=0xF; m_ack in cycle 1.
//     -> bus sees exact fields; d_ready=1 at cycle 2; i_ready stays 0.
//   - Contention, fixed: i_req and d_req together, 3-cycle ack latency -> D served first, then I. m_req never overlaps.
//     With ARB_RR_EN, two back-to-back ties -> order D, I, D, I.
//   - I read: i_addr=0x400, m_rdata=0x12345678 at ack -> i_rdata=0x12345678 with i_ready=1 for exactly one cycle.
//   - Watchdog: MAX_WAIT=4, no m_ack -> m_req drops after 4 bus cycles.
//     Next cycle owner ready=1, bus_err=1, rdata=0. A late m_ack 2 cycles later is ignored.
//   - Reset mid-BUS: rst=0 while m_req=1, then m_ack arrives -> m_req=0 after the edge, no ready, FSM in IDLE.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the I/D memory bus arbiter: FSM state codes, bus owner
// codes and the default bus widths used by the interface.
package mem_bus_arbiter_pkg;

    localparam int ARB_ADDR_W_DEF = 32;
    localparam int ARB_DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUS  = 2'd1,
        ARB_RESP = 2'd2
    } arbState_e;

    typedef enum logic {
        ARB_OWN_I = 1'b0,
        ARB_OWN_D = 1'b1
    } arbOwner_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundles the fetch port, the MEM-stage data port and the memory bus.
// slave  : the arbiter's view (serves I/D requests, drives the bus command).
// master : the surrounding pipeline and memory (raise requests, answer the bus).
interface mem_bus_arbiter_if
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W_DEF,
    parameter int DATA_W = ARB_DATA_W_DEF
);
    logic                i_req;
    logic [ADDR_W-1:0]   i_addr;
    logic [DATA_W-1:0]   i_rdata;
    logic                i_ready;

    logic                d_req;
    logic                d_we;
    logic [DATA_W/8-1:0] d_wstrb;
    logic [ADDR_W-1:0]   d_addr;
    logic [DATA_W-1:0]   d_wdata;
    logic [DATA_W-1:0]   d_rdata;
    logic                d_ready;

    logic                m_req;
    logic                m_we;
    logic [DATA_W/8-1:0] m_wstrb;
    logic [ADDR_W-1:0]   m_addr;
    logic [DATA_W-1:0]   m_wdata;
    logic [DATA_W-1:0]   m_rdata;
    logic                m_ack;
    logic                bus_err;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_wstrb, d_addr, d_wdata, m_rdata, m_ack,
        output i_rdata, i_ready, d_rdata, d_ready,
               m_req, m_we, m_wstrb, m_addr, m_wdata, bus_err
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_wstrb, d_addr, d_wdata, m_rdata, m_ack,
        input  i_rdata, i_ready, d_rdata, d_ready,
               m_req, m_we, m_wstrb, m_addr, m_wdata, bus_err
    );

endinterface

// File: rtl/mem_bus_arbiter_arb_grant_sel.sv
// Combinational grant selection between fetch (I) and data (D) requests.
// ARB_RR_EN undefined: fixed priority, D over I.
// ARB_RR_EN defined  : round-robin on ties, using the last-served owner.
module arb_grant_sel
    import mem_bus_arbiter_pkg::*;
(
    input  logic      iReq,
    input  logic      dReq,
`ifdef ARB_RR_EN
    input  arbOwner_e lastServed,
`endif
    output logic      grantValid,
    output arbOwner_e grantOwner
);

    // Pick the owner of the next bus transaction.
    always_comb begin
        grantValid = iReq | dReq;
        grantOwner = ARB_OWN_D;
`ifdef ARB_RR_EN
        if (iReq && dReq) begin
            grantOwner = (lastServed == ARB_OWN_D) ? ARB_OWN_I : ARB_OWN_D;
        end else if (iReq) begin
            grantOwner = ARB_OWN_I;
        end
`else
        // D first: the older instruction must finish or MEM and IF deadlock.
        if (iReq && !dReq) begin
            grantOwner = ARB_OWN_I;
        end
`endif
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one variable-latency memory bus between instruction fetch and MEM
// data access. One transaction at a time: IDLE (arbitrate) -> BUS (wait for
// ack or watchdog) -> RESP (one-cycle ready pulse). All outputs registered.
// Optional macro ARB_RR_EN selects round-robin arbitration instead of
// fixed D-over-I priority.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 255
)(
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.slave  bus
);

    localparam int WDOG_W = $clog2(MAX_WAIT + 1);

    arbState_e         state;
    arbState_e         stateNext;
    arbOwner_e         owner;
    logic [WDOG_W-1:0] wdog;

    logic              grantValid;
    arbOwner_e         grantOwner;
    logic              loadCmd;
    logic              finishAck;
    logic              finishAbort;
    logic              wdogStep;
    logic              wdogExpire;
    logic [ADDR_W-1:0] cmdAddr;

`ifdef ARB_RR_EN
    arbOwner_e         lastServed;
`endif

    arb_grant_sel uGrantSel (
        .iReq       (bus.i_req),
        .dReq       (bus.d_req),
`ifdef ARB_RR_EN
        .lastServed (lastServed),
`endif
        .grantValid (grantValid),
        .grantOwner (grantOwner)
    );

    // The watchdog counts completed bus cycles; the last allowed one is MAX_WAIT-1.
    assign wdogExpire = (wdog == WDOG_W'(MAX_WAIT - 1));
    assign cmdAddr    = (grantOwner == ARB_OWN_D) ? bus.d_addr : bus.i_addr;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state and the per-cycle actions of the current state.
    always_comb begin
        stateNext   = state;
        loadCmd     = 1'b0;
        finishAck   = 1'b0;
        finishAbort = 1'b0;
        wdogStep    = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (grantValid) begin
                    loadCmd   = 1'b1;
                    stateNext = ARB_BUS;
                end
            end
            ARB_BUS: begin
                // An ack arriving on the expiry cycle still completes normally.
                if (bus.m_ack) begin
                    finishAck = 1'b1;
                    stateNext = ARB_RESP;
                end else if (wdogExpire) begin
                    finishAbort = 1'b1;
                    stateNext   = ARB_RESP;
                end else begin
                    wdogStep = 1'b1;
                end
            end
            ARB_RESP: stateNext = ARB_IDLE;
            default:  stateNext = ARB_IDLE;
        endcase
    end

    // Command, watchdog and response registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner       <= ARB_OWN_D;
            wdog        <= '0;
            bus.m_req   <= 1'b0;
            bus.m_we    <= 1'b0;
            bus.m_wstrb <= '0;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
            bus.i_rdata <= '0;
            bus.i_ready <= 1'b0;
            bus.d_rdata <= '0;
            bus.d_ready <= 1'b0;
            bus.bus_err <= 1'b0;
        end else begin
            // Response outputs are pulses; read data is only non-zero beside ready.
            bus.i_ready <= 1'b0;
            bus.d_ready <= 1'b0;
            bus.bus_err <= 1'b0;
            bus.i_rdata <= '0;
            bus.d_rdata <= '0;
            if (loadCmd) begin
                owner       <= grantOwner;
                wdog        <= '0;
                bus.m_req   <= 1'b1;
                bus.m_addr  <= cmdAddr;
                // Fetch is read-only, so its write fields are forced to zero.
                bus.m_we    <= (grantOwner == ARB_OWN_D) ? bus.d_we    : 1'b0;
                bus.m_wstrb <= (grantOwner == ARB_OWN_D) ? bus.d_wstrb : '0;
                bus.m_wdata <= (grantOwner == ARB_OWN_D) ? bus.d_wdata : '0;
            end
            if (wdogStep) begin
                wdog <= wdog + WDOG_W'(1);
            end
            if (finishAck || finishAbort) begin
                bus.m_req   <= 1'b0;
                bus.bus_err <= finishAbort;
                if (owner == ARB_OWN_D) begin
                    bus.d_ready <= 1'b1;
                    bus.d_rdata <= finishAck ? bus.m_rdata : '0;
                end else begin
                    bus.i_ready <= 1'b1;
                    bus.i_rdata <= finishAck ? bus.m_rdata : '0;
                end
            end
        end
    end

`ifdef ARB_RR_EN
    // Remember who was granted last so the next tie goes the other way.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lastServed <= ARB_OWN_I;
        end else if (loadCmd) begin
            lastServed <= grantOwner;
        end
    end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter (MAX_WAIT = 4). Builds with or
// without ARB_RR_EN; the back-to-back tie order follows the macro.
module tb_mem_bus_arbiter;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [31:0] grantLog[$];
    logic overlapSeen;
    int   pendingLeft;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs I and D requesters against a bus that acks on bus cycle 'lat'.
    // Each requester re-requests until served the given number of times.
    task automatic drive_pair(input int lat, input int iTimes, input int dTimes);
        int  iLeft;
        int  dLeft;
        int  wc;
        logic prev;
        iLeft = iTimes;
        dLeft = dTimes;
        wc = 0;
        prev = 1'b0;
        overlapSeen = 1'b0;
        grantLog.delete();
        bus.i_req = (iLeft > 0);
        bus.d_req = (dLeft > 0);
        for (int c = 0; c < 200 && (iLeft > 0 || dLeft > 0); c++) begin
            tick();
            if (bus.m_req && !prev) begin
                grantLog.push_back(bus.m_addr);
                wc = 0;
            end
            if (bus.i_ready && bus.d_ready) overlapSeen = 1'b1;
            if (bus.i_ready) begin
                iLeft--;
                bus.i_req = (iLeft > 0);
            end
            if (bus.d_ready) begin
                dLeft--;
                bus.d_req = (dLeft > 0);
            end
            if (bus.m_req) begin
                wc++;
                bus.m_ack = (wc == lat);
            end else begin
                bus.m_ack = 1'b0;
            end
            prev = bus.m_req;
        end
        bus.m_ack = 1'b0;
        pendingLeft = iLeft + dLeft;
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus.i_req = 1'b1;
        bus.i_addr = 32'h100;
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_addr = 32'h20;
        bus.d_wdata = 32'h1111_2222;
        bus.d_wstrb = 4'hF;
        tick();
        tick();
        checks++;
        if ({bus.m_req, bus.m_we, bus.m_wstrb, bus.i_ready, bus.d_ready, bus.bus_err} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got m_req=%0b m_we=%0b m_wstrb=%h i_ready=%0b d_ready=%0b bus_err=%0b, want all 0",
                     bus.m_req, bus.m_we, bus.m_wstrb, bus.i_ready, bus.d_ready, bus.bus_err);
        end
        checks++;
        if ({bus.m_addr, bus.m_wdata, bus.i_rdata, bus.d_rdata} !== 128'b0) begin
            errors++;
            $display("FAIL reset_data: got m_addr=%h m_wdata=%h i_rdata=%h d_rdata=%h, want all 0",
                     bus.m_addr, bus.m_wdata, bus.i_rdata, bus.d_rdata);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h20) begin
            errors++;
            $display("FAIL reset_first_grant: got m_req=%0b m_addr=%h, want 1 / 00000020", bus.m_req, bus.m_addr);
        end
        bus.m_rdata = 32'hA5A5_0001;
        bus.m_ack = 1'b1;
        tick();
        checks++;
        if (bus.d_ready !== 1'b1 || bus.d_rdata !== 32'hA5A5_0001 || bus.i_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_resp: got d_ready=%0b d_rdata=%h i_ready=%0b, want 1 / a5a50001 / 0",
                     bus.d_ready, bus.d_rdata, bus.i_ready);
        end
        bus.m_ack = 1'b0;
        bus.d_req = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h100) begin
            errors++;
            $display("FAIL reset_second_grant: got m_req=%0b m_addr=%h, want 1 / 00000100", bus.m_req, bus.m_addr);
        end
        bus.m_ack = 1'b1;
        tick();
        bus.m_ack = 1'b0;
        bus.i_req = 1'b0;
        tick();
    endtask

    task automatic test_d_write;
        bus.d_req = 1'b1;
        bus.d_we = 1'b1;
        bus.d_addr = 32'h10;
        bus.d_wdata = 32'hDEAD_BEEF;
        bus.d_wstrb = 4'hF;
        tick();
        checks++;
        if (bus.m_req !== 1'b1 || bus.m_we !== 1'b1 || bus.m_addr !== 32'h10 ||
            bus.m_wdata !== 32'hDEAD_BEEF || bus.m_wstrb !== 4'hF) begin
            errors++;
            $display("FAIL dwr_cmd: got req=%0b we=%0b addr=%h wdata=%h wstrb=%h, want 1 1 00000010 deadbeef f",
                     bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_wstrb);
        end
        bus.m_ack = 1'b1;
        bus.m_rdata = 32'h0;
        tick();
        checks++;
        if (bus.d_ready !== 1'b1 || bus.i_ready !== 1'b0 || bus.m_req !== 1'b0) begin
            errors++;
            $display("FAIL dwr_ready: got d_ready=%0b i_ready=%0b m_req=%0b, want 1 0 0",
                     bus.d_ready, bus.i_ready, bus.m_req);
        end
        bus.m_ack = 1'b0;
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        tick();
        checks++;
        if (bus.d_ready !== 1'b0) begin
            errors++;
            $display("FAIL dwr_pulse: got d_ready=%0b one cycle later, want 0", bus.d_ready);
        end
    endtask

    task automatic test_i_read;
        bus.i_req = 1'b1;
        bus.i_addr = 32'h400;
        bus.d_wstrb = 4'hA;
        tick();
        checks++;
        if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h400 || bus.m_we !== 1'b0 || bus.m_wstrb !== 4'h0) begin
            errors++;
            $display("FAIL iread_cmd: got req=%0b addr=%h we=%0b wstrb=%h, want 1 00000400 0 0",
                     bus.m_req, bus.m_addr, bus.m_we, bus.m_wstrb);
        end
        bus.m_ack = 1'b1;
        bus.m_rdata = 32'h1234_5678;
        tick();
        checks++;
        if (bus.i_ready !== 1'b1 || bus.i_rdata !== 32'h1234_5678 || bus.d_ready !== 1'b0 || bus.d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL iread_resp: got i_ready=%0b i_rdata=%h d_ready=%0b d_rdata=%h, want 1 12345678 0 0",
                     bus.i_ready, bus.i_rdata, bus.d_ready, bus.d_rdata);
        end
        bus.m_ack = 1'b0;
        bus.i_req = 1'b0;
        tick();
        checks++;
        if (bus.i_ready !== 1'b0 || bus.i_rdata !== 32'h0) begin
            errors++;
            $display("FAIL iread_pulse: got i_ready=%0b i_rdata=%h, want 0 0", bus.i_ready, bus.i_rdata);
        end
    endtask

    task automatic test_contention;
        bus.i_addr = 32'h400;
        bus.d_addr = 32'h80;
        bus.d_we = 1'b0;
        drive_pair(3, 1, 1);
        checks++;
        if (pendingLeft !== 0 || grantLog.size() !== 2) begin
            errors++;
            $display("FAIL contention_count: got pending=%0d grants=%0d, want 0 2", pendingLeft, grantLog.size());
        end else begin
            checks++;
            if (grantLog[0] !== 32'h80 || grantLog[1] !== 32'h400) begin
                errors++;
                $display("FAIL contention_order: got %h then %h, want 00000080 then 00000400", grantLog[0], grantLog[1]);
            end
        end
        checks++;
        if (overlapSeen !== 1'b0) begin
            errors++;
            $display("FAIL contention_overlap: got both readies together, want never");
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] expOrder[4];
`ifdef ARB_RR_EN
        expOrder = '{32'h80, 32'h400, 32'h80, 32'h400};
`else
        expOrder = '{32'h80, 32'h80, 32'h400, 32'h400};
`endif
        drive_pair(1, 2, 2);
        checks++;
        if (pendingLeft !== 0 || grantLog.size() !== 4) begin
            errors++;
            $display("FAIL b2b_count: got pending=%0d grants=%0d, want 0 4", pendingLeft, grantLog.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (grantLog[k] !== expOrder[k]) begin
                    errors++;
                    $display("FAIL b2b_order[%0d]: got %h, want %h", k, grantLog[k], expOrder[k]);
                end
            end
        end
    endtask

    task automatic test_watchdog;
        bus.d_req = 1'b1;
        bus.d_addr = 32'h44;
        bus.m_rdata = 32'hFFFF_FFFF;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (bus.m_req !== 1'b1 || bus.d_ready !== 1'b0) begin
                errors++;
                $display("FAIL wdog_wait[%0d]: got m_req=%0b d_ready=%0b, want 1 0", k, bus.m_req, bus.d_ready);
            end
        end
        tick();
        checks++;
        if (bus.m_req !== 1'b0 || bus.d_ready !== 1'b1 || bus.bus_err !== 1'b1 || bus.d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL wdog_abort: got m_req=%0b d_ready=%0b bus_err=%0b d_rdata=%h, want 0 1 1 0",
                     bus.m_req, bus.d_ready, bus.bus_err, bus.d_rdata);
        end
        bus.d_req = 1'b0;
        tick();
        checks++;
        if (bus.bus_err !== 1'b0 || bus.d_ready !== 1'b0) begin
            errors++;
            $display("FAIL wdog_pulse: got bus_err=%0b d_ready=%0b, want 0 0", bus.bus_err, bus.d_ready);
        end
        bus.m_ack = 1'b1;
        bus.m_rdata = 32'h0000_0BAD;
        tick();
        checks++;
        if ({bus.m_req, bus.d_ready, bus.i_ready, bus.bus_err} !== 4'b0 || bus.d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL wdog_late_ack: got m_req=%0b d_ready=%0b i_ready=%0b bus_err=%0b d_rdata=%h, want all 0",
                     bus.m_req, bus.d_ready, bus.i_ready, bus.bus_err, bus.d_rdata);
        end
        bus.m_ack = 1'b0;
        bus.d_req = 1'b1;
        bus.d_addr = 32'h48;
        tick();
        tick();
        tick();
        tick();
        bus.m_ack = 1'b1;
        bus.m_rdata = 32'h600D_F00D;
        tick();
        checks++;
        if (bus.d_ready !== 1'b1 || bus.d_rdata !== 32'h600D_F00D || bus.bus_err !== 1'b0) begin
            errors++;
            $display("FAIL wdog_ack_tie: got d_ready=%0b d_rdata=%h bus_err=%0b, want 1 600df00d 0",
                     bus.d_ready, bus.d_rdata, bus.bus_err);
        end
        bus.m_ack = 1'b0;
        bus.d_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_bus;
        bus.d_req = 1'b1;
        bus.d_addr = 32'h60;
        tick();
        checks++;
        if (bus.m_req !== 1'b1) begin
            errors++;
            $display("FAIL midrst_start: got m_req=%0b, want 1", bus.m_req);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.m_req !== 1'b0 || bus.d_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_drop: got m_req=%0b d_ready=%0b, want 0 0", bus.m_req, bus.d_ready);
        end
        rst = 1'b1;
        bus.d_req = 1'b0;
        bus.m_ack = 1'b1;
        bus.m_rdata = 32'h0000_0077;
        tick();
        checks++;
        if (bus.m_req !== 1'b0 || bus.d_ready !== 1'b0 || bus.d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL midrst_ack: got m_req=%0b d_ready=%0b d_rdata=%h, want 0 0 0",
                     bus.m_req, bus.d_ready, bus.d_rdata);
        end
        bus.m_ack = 1'b0;
        bus.d_req = 1'b1;
        tick();
        checks++;
        if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h60) begin
            errors++;
            $display("FAIL midrst_idle: got m_req=%0b m_addr=%h, want 1 00000060", bus.m_req, bus.m_addr);
        end
        bus.m_ack = 1'b1;
        tick();
        bus.m_ack = 1'b0;
        bus.d_req = 1'b0;
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        bus.i_req = 1'b0;
        bus.i_addr = '0;
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        bus.d_wstrb = '0;
        bus.d_addr = '0;
        bus.d_wdata = '0;
        bus.m_rdata = '0;
        bus.m_ack = 1'b0;
        test_reset();
        test_d_write();
        test_i_read();
        test_contention();
        test_back_to_back();
        test_watchdog();
        test_reset_mid_bus();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
